// File: rtl/ahbl_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO slave: register map offsets,
// register index encoding and the value returned for unmapped reads.
package ahbl_gpio_pkg;

  // Register index inside one port window, taken from HADDR[4:2]
  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_SET     = 3'd2,
    REG_CLR     = 3'd3,
    REG_TGL     = 3'd4,
    REG_RISE_EN = 3'd5,
    REG_FALL_EN = 3'd6,
    REG_STATUS  = 3'd7
  } gpio_reg_e;

  localparam logic [4:0]  OFS_DATA    = 5'h00;
  localparam logic [4:0]  OFS_DIR     = 5'h04;
  localparam logic [4:0]  OFS_SET     = 5'h08;
  localparam logic [4:0]  OFS_CLR     = 5'h0C;
  localparam logic [4:0]  OFS_TGL     = 5'h10;
  localparam logic [4:0]  OFS_RISE_EN = 5'h14;
  localparam logic [4:0]  OFS_FALL_EN = 5'h18;
  localparam logic [4:0]  OFS_STATUS  = 5'h1C;
  localparam logic [31:0] PORT_STRIDE = 32'h20;
  localparam logic [31:0] BAD_READ    = 32'hBADDBEEF;

  // Map a byte offset within a port window to its register index
  function automatic gpio_reg_e reg_index(input logic [4:0] ofs);
    return gpio_reg_e'(ofs[4:2]);
  endfunction

endpackage

// File: rtl/ahbl_gpio_irq_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the GPIO slave.
interface ahbl_gpio_irq_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HREADY, HSIZE, HWRITE, HSEL, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HREADY, HSIZE, HWRITE, HSEL, HWDATA,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahbl_gpio_irq_port.sv
// One GPIO port: output/direction registers, edge enables, sticky status,
// input synchroniser and edge detector. Bus decode happens in the top.
module gpio_port
  import ahbl_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             we,
  input  gpio_reg_e        reg_idx,
  input  logic [31:0]      wdata,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in, prev_q;
  logic [WIDTH-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [WIDTH-1:0] out_next, oe_next, rise_en_next, fall_en_next, status_next;
  logic [WIDTH-1:0] w1c, edge_evt, wd, rdata_w;
  logic             irq_next;

  assign wd       = wdata[WIDTH-1:0];
  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign edge_evt = (sync_in & ~prev_q & rise_en_q) | (~sync_in & prev_q & fall_en_q);

  // Next-state of the bus-visible registers; a new edge beats a W1C on the same bit
  always_comb begin
    out_next     = out_q;
    oe_next      = oe_q;
    rise_en_next = rise_en_q;
    fall_en_next = fall_en_q;
    w1c          = '0;
    if (we) begin
      unique case (reg_idx)
        REG_DATA:    out_next     = wd;
        REG_DIR:     oe_next      = wd;
        REG_SET:     out_next     = out_q | wd;
        REG_CLR:     out_next     = out_q & ~wd;
        REG_TGL:     out_next     = out_q ^ wd;
        REG_RISE_EN: rise_en_next = wd;
        REG_FALL_EN: fall_en_next = wd;
        REG_STATUS:  w1c          = wd;
        default:     ;
      endcase
    end
    status_next = (status_q & ~w1c) | edge_evt;
    irq_next    = |(status_next & (rise_en_next | fall_en_next));
  end

  // Register state, synchroniser chain, previous sample and the port interrupt flop
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq       <= 1'b0;
    end else begin
      sync_q[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= sync_in;
      out_q     <= out_next;
      oe_q      <= oe_next;
      rise_en_q <= rise_en_next;
      fall_en_q <= fall_en_next;
      status_q  <= status_next;
      irq       <= irq_next;
    end
  end

  // Read mux; SET/CLR/TGL are write-only and read as zero
  always_comb begin
    rdata_w = '0;
    unique case (reg_idx)
      REG_DATA:    rdata_w = sync_in;
      REG_DIR:     rdata_w = oe_q;
      REG_RISE_EN: rdata_w = rise_en_q;
      REG_FALL_EN: rdata_w = fall_en_q;
      REG_STATUS:  rdata_w = status_q;
      default:     rdata_w = '0;
    endcase
  end

  assign rdata    = 32'(rdata_w);
  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

endmodule

// File: rtl/ahbl_gpio_irq.sv
// AHB-Lite GPIO slave with edge interrupts: latches the address phase,
// decodes the port window and register, and combines per-port read data and IRQs.
module ahbl_gpio_irq
  import ahbl_gpio_pkg::*;
#(
  parameter int NPORTS      = 3,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  ahbl_gpio_irq_if.slave          ahb,
  input  logic [NPORTS*WIDTH-1:0] GPIO_IN,
  output logic [NPORTS*WIDTH-1:0] GPIO_OUT,
  output logic [NPORTS*WIDTH-1:0] GPIO_OE,
  output logic                    IRQ
);

  logic        sel_d, trans_d, write_d;
  logic [23:0] addr_d;
  logic [18:0] port_sel;
  logic        aligned, write_act;
  gpio_reg_e   reg_idx;
  logic [NPORTS-1:0] port_we, port_irq;
  logic [31:0] port_rdata [NPORTS];
  logic [31:0] hrdata_mux;
  logic        unused_bus;

  assign unused_bus = ^{ahb.HSIZE, ahb.HADDR[31:24], ahb.HTRANS[0]};

  // Capture the address phase whenever the bus advances
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_d   <= 1'b0;
      trans_d <= 1'b0;
      write_d <= 1'b0;
      addr_d  <= '0;
    end else if (ahb.HREADY) begin
      sel_d   <= ahb.HSEL;
      trans_d <= ahb.HTRANS[1];
      write_d <= ahb.HWRITE;
      addr_d  <= ahb.HADDR[23:0];
    end
  end

  assign port_sel  = addr_d[23:5];
  assign aligned   = (addr_d[1:0] == 2'b00);
  assign write_act = sel_d & trans_d & write_d;
  assign reg_idx   = reg_index(addr_d[4:0]);

  // Port select for writes and read-data mux; unmapped windows read BAD_READ
  always_comb begin
    port_we    = '0;
    hrdata_mux = BAD_READ;
    for (int p = 0; p < NPORTS; p++) begin
      if (aligned && port_sel == 19'(p)) begin
        port_we[p] = write_act;
        hrdata_mux = port_rdata[p];
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    gpio_port #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .we       (port_we[p]),
      .reg_idx  (reg_idx),
      .wdata    (ahb.HWDATA),
      .pad_in   (GPIO_IN[p*WIDTH +: WIDTH]),
      .gpio_out (GPIO_OUT[p*WIDTH +: WIDTH]),
      .gpio_oe  (GPIO_OE[p*WIDTH +: WIDTH]),
      .rdata    (port_rdata[p]),
      .irq      (port_irq[p])
    );
  end

  assign ahb.HRDATA    = hrdata_mux;
  assign ahb.HREADYOUT = 1'b1;
  assign IRQ           = |port_irq;

endmodule

// File: tb/tb_ahbl_gpio_irq.sv
// Directed testbench for ahbl_gpio_irq: a 3x32 instance for the main
// behaviour and a 2x8 instance for the narrow-port masking.
module tb_ahbl_gpio_irq;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] hwdata = '0;
  logic        target = 1'b0;
  logic [95:0] gpio_in1 = '0;
  logic [95:0] gpio_out1, gpio_oe1;
  logic        irq1;
  logic [15:0] gpio_in2 = '0;
  logic [15:0] gpio_out2, gpio_oe2;
  logic        irq2;
  logic [31:0] rd;
  int          total = 0;
  int          bad = 0;

  ahbl_gpio_irq_if bus1 ();
  ahbl_gpio_irq_if bus2 ();

  assign bus1.HADDR  = haddr;
  assign bus1.HTRANS = htrans;
  assign bus1.HREADY = 1'b1;
  assign bus1.HSIZE  = 3'b010;
  assign bus1.HWRITE = hwrite;
  assign bus1.HSEL   = hsel & ~target;
  assign bus1.HWDATA = hwdata;
  assign bus2.HADDR  = haddr;
  assign bus2.HTRANS = htrans;
  assign bus2.HREADY = 1'b1;
  assign bus2.HSIZE  = 3'b010;
  assign bus2.HWRITE = hwrite;
  assign bus2.HSEL   = hsel & target;
  assign bus2.HWDATA = hwdata;

  ahbl_gpio_irq #(.NPORTS(3), .WIDTH(32), .SYNC_STAGES(2)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .ahb      (bus1.slave),
    .GPIO_IN  (gpio_in1),
    .GPIO_OUT (gpio_out1),
    .GPIO_OE  (gpio_oe1),
    .IRQ      (irq1)
  );

  ahbl_gpio_irq #(.NPORTS(2), .WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .ahb      (bus2.slave),
    .GPIO_IN  (gpio_in2),
    .GPIO_OUT (gpio_out2),
    .GPIO_OE  (gpio_oe2),
    .IRQ      (irq2)
  );

  always #5 HCLK = ~HCLK;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One complete transfer followed by an idle cycle so a write has landed on return
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               output logic [31:0] rdata);
    @(posedge HCLK); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
    rdata = target ? bus2.HRDATA : bus1.HRDATA;
    @(posedge HCLK); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    checkOutput("rst_out", gpio_out1, 96'h0);
    checkOutput("rst_oe", gpio_oe1, 96'h0);
    checkOutput("rst_irq", {95'h0, irq1}, 96'h0);
    checkOutput("rst_hrdata", {64'h0, bus1.HRDATA}, 96'h0);
    checkOutput("rst_hreadyout", {95'h0, bus1.HREADYOUT}, 96'h1);
    HRESETn = 1'b1;
    gpio_in1[63:32] = 32'h13579BDF;

    // Reset asserted in the data phase of a write: nothing lands, DIR cleared
    applyStimulus(1'b1, 32'h04, 32'h00001234, rd);
    checkOutput("dir_before_rst", gpio_oe1, 96'h1234);
    @(posedge HCLK); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h00;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
    HRESETn = 1'b0;
    #2;
    checkOutput("async_rst_oe", gpio_oe1, 96'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    checkOutput("midwr_out", gpio_out1, 96'h0);
    checkOutput("midwr_oe", gpio_oe1, 96'h0);
    checkOutput("midwr_irq", {95'h0, irq1}, 96'h0);

    // Port 1 atomic output operations
    applyStimulus(1'b1, 32'h20, 32'hA5A5A5A5, rd);
    checkOutput("p1_data", gpio_out1, {32'h0, 32'hA5A5A5A5, 32'h0});
    applyStimulus(1'b1, 32'h28, 32'h0000000F, rd);
    checkOutput("p1_set", gpio_out1, {32'h0, 32'hA5A5A5AF, 32'h0});
    applyStimulus(1'b1, 32'h2C, 32'h000000A0, rd);
    checkOutput("p1_clr", gpio_out1, {32'h0, 32'hA5A5A50F, 32'h0});
    applyStimulus(1'b1, 32'h30, 32'hFFFF0000, rd);
    checkOutput("p1_tgl", gpio_out1, {32'h0, 32'h5A5AA50F, 32'h0});
    applyStimulus(1'b0, 32'h28, 32'h0, rd);
    checkOutput("p1_set_reads0", {64'h0, rd}, 96'h0);
    applyStimulus(1'b0, 32'h20, 32'h0, rd);
    checkOutput("p1_data_reads_pad", {64'h0, rd}, 96'h13579BDF);

    // Back-to-back write then read of port 2 DIR
    @(posedge HCLK); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h44;
    @(posedge HCLK); #1;
    hwdata = 32'hCAFE0001; hwrite = 1'b0;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00;
    checkOutput("b2b_read", {64'h0, bus1.HRDATA}, 96'hCAFE0001);
    checkOutput("b2b_oe", gpio_oe1, {32'hCAFE0001, 64'h0});

    // Rising edge on port 0 bit 3: data after 2 edges, status/IRQ after 3
    applyStimulus(1'b1, 32'h14, 32'h8, rd);
    @(posedge HCLK); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h00;
    gpio_in1[3] = 1'b1;
    @(posedge HCLK); #1;
    checkOutput("rise_data_e1", {64'h0, bus1.HRDATA}, 96'h0);
    checkOutput("rise_irq_e1", {95'h0, irq1}, 96'h0);
    @(posedge HCLK); #1;
    checkOutput("rise_data_e2", {64'h0, bus1.HRDATA}, 96'h8);
    checkOutput("rise_irq_e2", {95'h0, irq1}, 96'h0);
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00;
    checkOutput("rise_irq_e3", {95'h0, irq1}, 96'h1);
    applyStimulus(1'b0, 32'h1C, 32'h0, rd);
    checkOutput("rise_status", {64'h0, rd}, 96'h8);
    applyStimulus(1'b1, 32'h1C, 32'h8, rd);
    checkOutput("w1c_irq", {95'h0, irq1}, 96'h0);
    applyStimulus(1'b0, 32'h1C, 32'h0, rd);
    checkOutput("w1c_status", {64'h0, rd}, 96'h0);

    // Re-arm status with a fresh rising edge, then enable falling edges
    gpio_in1[3] = 1'b0;
    repeat (4) @(posedge HCLK);
    #1;
    checkOutput("fall_no_en_irq", {95'h0, irq1}, 96'h0);
    gpio_in1[3] = 1'b1;
    repeat (4) @(posedge HCLK);
    #1;
    checkOutput("rearm_irq", {95'h0, irq1}, 96'h1);
    applyStimulus(1'b1, 32'h18, 32'h8, rd);

    // W1C landing on the same edge that a falling edge sets the bit
    @(posedge HCLK); #1;
    gpio_in1[3] = 1'b0;
    @(posedge HCLK); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h1C;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h8;
    @(posedge HCLK); #1;
    checkOutput("race_irq", {95'h0, irq1}, 96'h1);
    applyStimulus(1'b0, 32'h1C, 32'h0, rd);
    checkOutput("race_status", {64'h0, rd}, 96'h8);

    // Clearing the enables masks IRQ but keeps STATUS
    applyStimulus(1'b1, 32'h14, 32'h0, rd);
    checkOutput("en_fall_only_irq", {95'h0, irq1}, 96'h1);
    applyStimulus(1'b1, 32'h18, 32'h0, rd);
    checkOutput("en_off_irq", {95'h0, irq1}, 96'h0);
    applyStimulus(1'b0, 32'h1C, 32'h0, rd);
    checkOutput("en_off_status", {64'h0, rd}, 96'h8);
    applyStimulus(1'b1, 32'h1C, 32'h8, rd);
    applyStimulus(1'b0, 32'h1C, 32'h0, rd);
    checkOutput("final_w1c_status", {64'h0, rd}, 96'h0);

    // Unmapped port and misaligned address
    applyStimulus(1'b0, 32'h60, 32'h0, rd);
    checkOutput("bad_port_read", {64'h0, rd}, 96'hBADDBEEF);
    applyStimulus(1'b0, 32'h02, 32'h0, rd);
    checkOutput("misalign_read", {64'h0, rd}, 96'hBADDBEEF);
    applyStimulus(1'b1, 32'h60, 32'hFFFFFFFF, rd);
    applyStimulus(1'b1, 32'h02, 32'hFFFFFFFF, rd);
    applyStimulus(1'b1, 32'h66, 32'hFFFFFFFF, rd);
    checkOutput("bad_write_out", gpio_out1, {32'h0, 32'h5A5AA50F, 32'h0});
    checkOutput("bad_write_oe", gpio_oe1, {32'hCAFE0001, 64'h0});

    // Narrow 8-bit ports: upper register bits ignored and read as zero
    target = 1'b1;
    applyStimulus(1'b1, 32'h04, 32'hFFFFFFFF, rd);
    applyStimulus(1'b0, 32'h04, 32'h0, rd);
    checkOutput("w8_dir_read", {64'h0, rd}, 96'h000000FF);
    checkOutput("w8_oe", {80'h0, gpio_oe2}, 96'h00FF);
    applyStimulus(1'b0, 32'h40, 32'h0, rd);
    checkOutput("w8_bad_port", {64'h0, rd}, 96'hBADDBEEF);
    checkOutput("w8_irq", {95'h0, irq2}, 96'h0);
    target = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
